// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Bundles every handshake and status signal between the rv64i multi-cycle
// sequencer and the surrounding core (IFU, decoder, EXU, LSU, PC/RF logic).
// clk and rst_n are plain module ports and are not part of this bundle.
//
// Handshake semantics, used for both the IFU and the LSU:
//   The sequencer raises a request (ifu_req_o / lsu_req_o) on every cycle it
//   is waiting. The responder answers with a one-cycle qualifier
//   (ifu_valid_i / lsu_done_i). The transfer completes on the rising edge
//   where request and qualifier are both high. A qualifier that arrives while
//   no request is raised is ignored, and a request is never withdrawn except
//   by a timeout or by reset.
//
// Modports:
//   master - the sequencer: drives the *_o signals, samples the *_i signals.
//   slave  - the core environment: the mirror image of master.
interface core_sequencer_if #(
  parameter int CNT_WIDTH = 64
);
  logic                 start_i;
  logic                 ifu_req_o;
  logic                 ifu_valid_i;
  logic                 ir_we_o;
  logic [4:0]           dec_enable_i;
  logic [2:0]           dec_specinst_i;
  logic                 dec_error_i;
  logic [1:0]           dec_env_i;
  logic                 branch_taken_i;
  logic                 lsu_req_o;
  logic                 lsu_we_o;
  logic                 lsu_done_i;
  logic                 rf_we_o;
  logic                 pc_we_o;
  logic [1:0]           pc_sel_o;
  logic                 trap_valid_o;
  logic [2:0]           trap_cause_o;
  logic                 halt_o;
  logic [2:0]           state_o;
  logic [CNT_WIDTH-1:0] instret_o;

  modport master (
    input  start_i, ifu_valid_i, dec_enable_i, dec_specinst_i, dec_error_i,
           dec_env_i, branch_taken_i, lsu_done_i,
    output ifu_req_o, ir_we_o, lsu_req_o, lsu_we_o, rf_we_o, pc_we_o,
           pc_sel_o, trap_valid_o, trap_cause_o, halt_o, state_o, instret_o
  );

  modport slave (
    output start_i, ifu_valid_i, dec_enable_i, dec_specinst_i, dec_error_i,
           dec_env_i, branch_taken_i, lsu_done_i,
    input  ifu_req_o, ir_we_o, lsu_req_o, lsu_we_o, rf_we_o, pc_we_o,
           pc_sel_o, trap_valid_o, trap_cause_o, halt_o, state_o, instret_o
  );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM for the rv64i core:
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH.
// It also handles traps (fetch/mem timeout, illegal, ecall), the ebreak halt
// and the retired-instruction counter.
//
// Ports:
//   clk   - core clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - core_sequencer_if.master: IFU/LSU handshakes, decoder inputs,
//           RF/PC/IR strobes, trap status, debug state and instret
//
// Parameters:
//   TIMEOUT   - wait cycles allowed in FETCH or MEM before a timeout trap
//               (0 disables the timeout)
//   CNT_WIDTH - width of instret_o; must match the interface parameter
module core_sequencer #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 64
) (
  input logic              clk,
  input logic              rst_n,
  core_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] SP_BR   = 3'd0;
  localparam logic [2:0] SP_JAL  = 3'd1;
  localparam logic [2:0] SP_JALR = 3'd2;

  localparam logic [2:0] C_FETCH_TO = 3'd1;
  localparam logic [2:0] C_ILLEGAL  = 3'd2;
  localparam logic [2:0] C_ECALL    = 3'd3;
  localparam logic [2:0] C_MEM_TO   = 3'd4;
  localparam logic [2:0] C_EBREAK   = 3'd5;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_TRAP   = 2'd2;

  localparam int         CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        wait_q;
  logic [4:0]           en_q;
  logic [2:0]           spec_q;
  logic [2:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] instret_q;

  logic       ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, trap_valid;
  logic [1:0] pc_sel;
  logic       timed_out;

  // wait_q holds the index of the current FETCH/MEM wait cycle; it is zero
  // on the first cycle because every state preceding FETCH or MEM clears it.
  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      en_q      <= '0;
      spec_q    <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_FETCH || state_q == S_MEM) wait_q <= wait_q + 1'b1;
      else                                        wait_q <= '0;
      if (state_q == S_DECODE) begin
        en_q   <= bus.dec_enable_i;
        spec_q <= bus.dec_specinst_i;
      end
      if (state_q == S_WB) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    ifu_req    = 1'b0;
    ir_we      = 1'b0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_SEQ;
    trap_valid = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_FETCH;
      S_FETCH: begin
        ifu_req = 1'b1;
        if (bus.ifu_valid_i) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = C_FETCH_TO;
        end
      end
      S_DECODE: begin
        // error beats ebreak beats ecall
        if (bus.dec_error_i) begin
          state_d = S_TRAP;
          cause_d = C_ILLEGAL;
        end else if (bus.dec_env_i[1]) begin
          state_d = S_HALT;
          cause_d = C_EBREAK;
        end else if (bus.dec_env_i[0]) begin
          state_d = S_TRAP;
          cause_d = C_ECALL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (en_q[3] | en_q[4]) ? S_MEM : S_WB;
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_we  = en_q[4];
        if (bus.lsu_done_i) begin
          state_d = S_WB;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = C_MEM_TO;
        end
      end
      S_WB: begin
        rf_we = en_q[2];
        pc_we = 1'b1;
        if (spec_q == SP_JAL || spec_q == SP_JALR ||
            (spec_q == SP_BR && bus.branch_taken_i))
          pc_sel = PC_TARGET;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap_valid = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = PC_TRAP;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ifu_req_o    = ifu_req;
  assign bus.ir_we_o      = ir_we;
  assign bus.lsu_req_o    = lsu_req;
  assign bus.lsu_we_o     = lsu_we;
  assign bus.rf_we_o      = rf_we;
  assign bus.pc_we_o      = pc_we;
  assign bus.pc_sel_o     = pc_sel;
  assign bus.trap_valid_o = trap_valid;
  assign bus.trap_cause_o = cause_q;
  // HALT is terminal until reset, so halt_o is sticky by construction.
  assign bus.halt_o       = (state_q == S_HALT);
  assign bus.state_o      = state_q;
  assign bus.instret_o    = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
// Directed bench for core_sequencer (TIMEOUT=16, CNT_WIDTH=64). Inputs are
// driven 1 time unit after the rising edge, outputs are checked 1 unit later.
module tb_core_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  logic [63:0] exp_instret;
  logic [2:0]  exp_q[$];

  core_sequencer_if #(.CNT_WIDTH(64)) bus();

  core_sequencer #(.TIMEOUT(16), .CNT_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start_i        = 1'b0;
    bus.ifu_valid_i    = 1'b0;
    bus.dec_enable_i   = 5'd0;
    bus.dec_specinst_i = 3'd7;
    bus.dec_error_i    = 1'b0;
    bus.dec_env_i      = 2'd0;
    bus.branch_taken_i = 1'b0;
    bus.lsu_done_i     = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".state"},   bus.state_o, 3'd0);
    check({tag, ".ifu_req"}, bus.ifu_req_o, 1'b0);
    check({tag, ".ir_we"},   bus.ir_we_o, 1'b0);
    check({tag, ".lsu_req"}, bus.lsu_req_o, 1'b0);
    check({tag, ".lsu_we"},  bus.lsu_we_o, 1'b0);
    check({tag, ".rf_we"},   bus.rf_we_o, 1'b0);
    check({tag, ".pc_we"},   bus.pc_we_o, 1'b0);
    check({tag, ".pc_sel"},  bus.pc_sel_o, 2'd0);
    check({tag, ".trap"},    bus.trap_valid_o, 1'b0);
    check({tag, ".cause"},   bus.trap_cause_o, 3'd0);
    check({tag, ".halt"},    bus.halt_o, 1'b0);
    check({tag, ".instret"}, bus.instret_o, 64'd0);
  endtask

  // Full instruction from the first FETCH cycle back to the next FETCH.
  task automatic run_instr(input string name, input logic [4:0] en, input logic [2:0] sp,
                           input logic taken, input int fwait, input int mwait,
                           input logic exp_rf, input logic [1:0] exp_sel, input int exp_lat);
    int  t0;
    bit  is_mem;
    is_mem = en[3] | en[4];
    for (int i = 0; i <= fwait; i++) exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    if (is_mem) for (int i = 0; i <= mwait; i++) exp_q.push_back(3'd4);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd1);

    t0 = cyc;
    bus.dec_enable_i   = en;
    bus.dec_specinst_i = sp;
    bus.dec_error_i    = 1'b0;
    bus.dec_env_i      = 2'd0;
    bus.branch_taken_i = taken;
    for (int i = 0; i <= fwait; i++) begin
      bus.ifu_valid_i = (i == fwait);
      #1;
      check({name, ".fetch_state"}, bus.state_o, exp_q.pop_front());
      check({name, ".ifu_req"}, bus.ifu_req_o, 1'b1);
      check({name, ".ir_we"}, bus.ir_we_o, (i == fwait));
      tick();
    end
    bus.ifu_valid_i = 1'b0;
    check({name, ".decode_state"}, bus.state_o, exp_q.pop_front());
    tick();
    check({name, ".exec_state"}, bus.state_o, exp_q.pop_front());
    tick();
    if (is_mem) begin
      for (int i = 0; i <= mwait; i++) begin
        bus.lsu_done_i = (i == mwait);
        #1;
        check({name, ".mem_state"}, bus.state_o, exp_q.pop_front());
        check({name, ".lsu_req"}, bus.lsu_req_o, 1'b1);
        check({name, ".lsu_we"}, bus.lsu_we_o, en[4]);
        tick();
      end
      bus.lsu_done_i = 1'b0;
    end
    check({name, ".wb_state"}, bus.state_o, exp_q.pop_front());
    check({name, ".rf_we"}, bus.rf_we_o, exp_rf);
    check({name, ".pc_we"}, bus.pc_we_o, 1'b1);
    check({name, ".pc_sel"}, bus.pc_sel_o, exp_sel);
    check({name, ".instret_wb"}, bus.instret_o, exp_instret);
    tick();
    exp_instret = exp_instret + 64'd1;
    check({name, ".next_state"}, bus.state_o, exp_q.pop_front());
    check({name, ".instret"}, bus.instret_o, exp_instret);
    check({name, ".latency"}, 64'(cyc - t0), 64'(exp_lat));
    check({name, ".rf_we_after"}, bus.rf_we_o, 1'b0);
  endtask

  // From FETCH, accept an instruction immediately; ends in DECODE.
  task automatic fetch_to_decode(input logic [4:0] en, input logic [2:0] sp,
                                 input logic err, input logic [1:0] env);
    bus.dec_enable_i   = en;
    bus.dec_specinst_i = sp;
    bus.dec_error_i    = err;
    bus.dec_env_i      = env;
    bus.ifu_valid_i    = 1'b1;
    tick();
    bus.ifu_valid_i    = 1'b0;
  endtask

  // Called on the TRAP cycle; ends back in FETCH.
  task automatic check_trap(input string name, input logic [2:0] cause);
    check({name, ".state"}, bus.state_o, 3'd6);
    check({name, ".trap_valid"}, bus.trap_valid_o, 1'b1);
    check({name, ".pc_we"}, bus.pc_we_o, 1'b1);
    check({name, ".pc_sel"}, bus.pc_sel_o, 2'd2);
    check({name, ".rf_we"}, bus.rf_we_o, 1'b0);
    check({name, ".cause"}, bus.trap_cause_o, cause);
    tick();
    check({name, ".resume_state"}, bus.state_o, 3'd1);
    check({name, ".trap_after"}, bus.trap_valid_o, 1'b0);
    check({name, ".cause_held"}, bus.trap_cause_o, cause);
    check({name, ".instret"}, bus.instret_o, exp_instret);
  endtask

  // stimulus
  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    exp_instret = 64'd0;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    rst_n = 1'b1;
    tick();
    check_quiet("idle_hold");
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("start.state", bus.state_o, 3'd1);

    //        name        enable    spec  tkn fw  mw  rf    sel  lat
    run_instr("addi",     5'b00101, 3'd7, 0,  0,  0,  1'b1, 2'd0, 4);
    run_instr("ld",       5'b01101, 3'd6, 0,  0,  2,  1'b1, 2'd0, 7);
    run_instr("sd",       5'b10011, 3'd5, 0,  0,  0,  1'b0, 2'd0, 5);
    run_instr("beq_t",    5'b00011, 3'd0, 1,  0,  0,  1'b0, 2'd1, 4);
    run_instr("beq_nt",   5'b00011, 3'd0, 0,  0,  0,  1'b0, 2'd0, 4);
    run_instr("jal",      5'b00100, 3'd1, 0,  0,  0,  1'b1, 2'd1, 4);
    run_instr("jalr",     5'b00101, 3'd2, 0,  3,  0,  1'b1, 2'd1, 7);
    run_instr("fetch_15", 5'b00101, 3'd7, 0,  15, 0,  1'b1, 2'd0, 19);
    run_instr("mem_15",   5'b01101, 3'd6, 0,  0,  15, 1'b1, 2'd0, 20);

    // fetch timeout: no valid through index 15
    for (int i = 0; i < 16; i++) begin
      check("fetch_to.wait_state", bus.state_o, 3'd1);
      tick();
    end
    check_trap("fetch_to", 3'd1);

    // mem timeout
    fetch_to_decode(5'b01101, 3'd6, 1'b0, 2'd0);
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      check("mem_to.wait_state", bus.state_o, 3'd4);
      check("mem_to.lsu_req", bus.lsu_req_o, 1'b1);
      tick();
    end
    check_trap("mem_to", 3'd4);

    // illegal wins over ebreak and ecall
    fetch_to_decode(5'b00101, 3'd7, 1'b1, 2'b11);
    bus.ifu_valid_i = 1'b1;   // stray valid in DECODE
    check("illegal.decode", bus.state_o, 3'd2);
    tick();
    bus.ifu_valid_i = 1'b0;
    check_trap("illegal", 3'd2);

    fetch_to_decode(5'b00000, 3'd7, 1'b0, 2'b01);
    tick();
    check_trap("ecall", 3'd3);

    // reset in the middle of MEM
    fetch_to_decode(5'b01101, 3'd6, 1'b0, 2'd0);
    tick();
    tick();
    check("rst_mem.lsu_req", bus.lsu_req_o, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_instret = 64'd0;
    check_quiet("rst_mem");
    bus.lsu_done_i = 1'b1;
    tick();
    bus.lsu_done_i = 1'b0;
    check_quiet("late_done");
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("restart.state", bus.state_o, 3'd1);

    run_instr("addi_2",   5'b00101, 3'd7, 0,  0,  0,  1'b1, 2'd0, 4);

    // ebreak with ecall also high -> HALT
    fetch_to_decode(5'b00000, 3'd7, 1'b0, 2'b11);
    tick();
    bus.ifu_valid_i = 1'b1;
    bus.start_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("halt.state", bus.state_o, 3'd7);
      check("halt.halt", bus.halt_o, 1'b1);
      check("halt.cause", bus.trap_cause_o, 3'd5);
      check("halt.ifu_req", bus.ifu_req_o, 1'b0);
      check("halt.pc_we", bus.pc_we_o, 1'b0);
      check("halt.trap", bus.trap_valid_o, 1'b0);
      check("halt.instret", bus.instret_o, exp_instret);
      tick();
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the rv64i core. It sequences fetch, decode, execute, memory and writeback using the decoder's enable, specinst, error and env-exception outputs. It handshakes with the IFU and LSU, generates the IR, RF and PC write strobes and the PC-select, and handles traps, ebreak halt and bus timeouts. It also maintains the retired-instruction counter.

Parameters:
TIMEOUT, 16, maximum cycles spent waiting in FETCH or MEM for a response before a timeout trap; 0 disables the timeout.
CNT_WIDTH, 64, width of the instret counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
start_i  input  1  level; leaves IDLE when high.
ifu_req_o  output  1  fetch request; high during every FETCH cycle.
ifu_valid_i  input  1  fetched instruction is valid this cycle.
ir_we_o  output  1  load the instruction register; equals ifu_valid_i while in FETCH.
dec_enable_i  input  5  decoder enables: bit0 RS1, bit1 RS2, bit2 RD, bit3 MREAD, bit4 MWRITE.
dec_specinst_i  input  3  decoder specinst: 0 BR, 1 JAL, 2 JALR, 3 AUIPC, 4 LUI, 5 STORE, 6 LOAD, 7 NONE.
dec_error_i  input  1  decode error.
dec_env_i  input  2  bit0 ecall, bit1 ebreak.
branch_taken_i  input  1  branch condition from the EXU; sampled in WB.
lsu_req_o  output  1  memory request; high during every MEM cycle.
lsu_we_o  output  1  store, not load; valid while lsu_req_o is high.
lsu_done_i  input  1  memory access complete.
rf_we_o  output  1  register-file write strobe; 1-cycle pulse.
pc_we_o  output  1  PC update strobe; 1-cycle pulse.
pc_sel_o  output  2  PC source: 0 = pc+4, 1 = target (branch/jal/jalr), 2 = trap vector.
trap_valid_o  output  1  1-cycle pulse while in TRAP.
trap_cause_o  output  3  0 none, 1 fetch timeout, 2 illegal, 3 ecall, 4 mem timeout, 5 ebreak; held until the next trap or reset.
halt_o  output  1  sticky high after ebreak.
state_o  output  3  current state, for debug.
instret_o  output  CNT_WIDTH  retired instruction count.

Behaviour:
- Reset: rst_n low at an edge forces state IDLE=0. At the same edge: all outputs 0, instret_o=0, trap_cause_o=0, latched controls cleared, timeout counter 0. Applies from any state, including mid-FETCH or mid-MEM; lsu_req_o and ifu_req_o drop after that edge. Any pending IFU/LSU response after reset is ignored.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6, HALT=7.
- IDLE: if start_i is high, go to FETCH; otherwise stay.
- FETCH: ifu_req_o=1. If ifu_valid_i is high, ir_we_o=1 in the same cycle and go to DECODE. Valid is accepted on any FETCH cycle, including the first.
- FETCH timeout: wait cycles are counted from 0. If no valid has arrived by cycle index TIMEOUT-1, go to TRAP with cause 1. Valid on index TIMEOUT-1 is still accepted. Valid and timeout never coincide.
- DECODE, 1 cycle: latch dec_enable_i and dec_specinst_i. Priority: dec_error_i goes to TRAP with cause 2; else ebreak (dec_env_i[1]) goes to HALT with cause 5; else ecall (dec_env_i[0]) goes to TRAP with cause 3; else go to EXEC.
- EXEC, 1 cycle: if latched MREAD or MWRITE is set, go to MEM; otherwise go to WB.
- MEM: lsu_req_o=1 and lsu_we_o=latched MWRITE. lsu_done_i goes to WB. Timeout rule is identical to FETCH, with cause 4. The timeout counter clears on entry to FETCH and to MEM.
- WB, 1 cycle: rf_we_o = latched RD; pc_we_o=1; instret_o increments by 1 (wraps at 2^CNT_WIDTH). Then go to FETCH.
- WB pc_sel_o: 1 if specinst is JAL or JALR, or if specinst is BR and branch_taken_i is high; 0 otherwise.
- TRAP, 1 cycle: trap_valid_o=1, pc_we_o=1, pc_sel_o=2, rf_we_o=0, instret unchanged. Then go to FETCH.
- HALT: halt_o=1. All strobes and requests are 0. Terminal until reset.
- Stray handshakes: ifu_valid_i outside FETCH and lsu_done_i outside MEM are ignored.
- pc_sel_o outside WB and TRAP is 0.
- Latency: minimum 4 cycles for ALU and branch instructions; minimum 5 for loads and stores; each extra wait cycle adds 1.
- TIMEOUT=0: no timeout; waits indefinitely.
- start_i is sampled only in IDLE.

Test Plan:
- ALU retire: addi word 0x00100093, ifu_valid on the first FETCH cycle -> states 1,2,3,5; rf_we_o pulses in WB with pc_sel_o=0; instret_o goes 0->1; back to FETCH 4 cycles after entry.
- Load with 3-cycle LSU wait: ld word 0x0000B103, lsu_done on the 3rd MEM cycle -> lsu_req_o high for 3 cycles with lsu_we_o=0; rf_we_o=1 in WB; 7 cycles total. Store 0x0020B023 -> lsu_we_o=1 and rf_we_o=0 in WB.
- Branch resolution: beq, specinst 0 -> with branch_taken_i=1, pc_sel_o=1 and rf_we_o=0; with branch_taken_i=0, pc_sel_o=0. jal -> pc_sel_o=1 and rf_we_o=1.
- Decode exceptions: dec_error_i=1 -> TRAP, cause 2, pc_sel_o=2, instret unchanged. ecall -> cause 3. ebreak (also with ecall high) -> HALT, halt_o sticky, cause 5, no further ifu_req_o.
- Timeouts with TIMEOUT=16: ifu_valid on index 15 -> DECODE; ifu_valid absent through index 15 -> TRAP cause 1. Same for MEM -> cause 4. After a trap, FETCH resumes.
- Reset mid-MEM: rst_n low for 1 edge while lsu_req_o=1 -> next cycle state 0, all outputs 0, instret_o=0. A late lsu_done_i is ignored. start_i=1 -> FETCH.
